fx_writeback_queue: RTL and testbench

FX_WRITEBACK_QUEUE -- requirements
Module: fx_writeback_queue

---
 rtl/fx_writeback_queue_pkg.sv | 33 +++
 rtl/fx_wb_select.sv | 79 +++++++
 rtl/fx_writeback_queue.sv | 176 +++++++++++++++++
 tb/tb_fx_writeback_queue.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_writeback_queue_pkg.sv
// rtl/fx_writeback_queue_pkg.sv - shared fixed-point widths and writeback entry layout
//
// Purpose: common definitions for the FX register file and its writeback queue.
//   - default GPR/XER data width and GPR address width
//   - default writeback queue depth and number of register-file write ports
//   - bit layout of a packed queue entry: {addr, val, xerEn, xerVal}, with
//     xerVal in the least significant bits
package fx_writeback_queue_pkg;

  localparam int unsigned fxRegSize      = 64;
  localparam int unsigned fxGprAddrBits  = 6;
  localparam int unsigned fxWbQueueDepth = 8;
  localparam int unsigned fxWbPorts      = 4;

  // Entry field positions. xerVal starts at bit 0.
  function automatic int unsigned entryXerEnBit(input int unsigned regSize);
    return regSize;
  endfunction

  function automatic int unsigned entryValLsb(input int unsigned regSize);
    return regSize + 1;
  endfunction

  function automatic int unsigned entryAddrLsb(input int unsigned regSize);
    return 2 * regSize + 1;
  endfunction

  function automatic int unsigned entryBits(input int unsigned regSize,
                                            input int unsigned addrBits);
    return 2 * regSize + 1 + addrBits;
  endfunction

endpackage

// File: rtl/fx_wb_select.sv
// rtl/fx_wb_select.sv - combinational drain-group selection for the writeback queue
//
// Purpose: from the four oldest queue entries, pick the longest age-ordered
// prefix that holds no repeated GPR address, route it to write ports in age
// order, and pick the XER update from the youngest selected entry that has one.
//
// Ports:
//   availCount  in   number of valid entries in the queue (candidates beyond it are ignored)
//   candAddr    in   candidate GPR addresses, index 0 = oldest
//   candVal     in   candidate GPR data
//   candXerEn   in   candidate also writes XER
//   candXerVal  in   candidate XER data
//   drainCount  out  number of entries selected (0..4)
//   portEn      out  per write port enable
//   portAddr    out  per write port address (0 when disabled)
//   portVal     out  per write port data (0 when disabled)
//   xerEn       out  an XER write is part of this group
//   xerVal      out  XER data (0 when xerEn=0)
module fx_wb_select
  import fx_writeback_queue_pkg::*;
#(
  parameter int unsigned regSize           = fxRegSize,
  parameter int unsigned numGPRAddressBits = fxGprAddrBits,
  parameter int unsigned cntWidth          = 4
) (
  input  logic [cntWidth-1:0]          availCount,
  input  logic [numGPRAddressBits-1:0] candAddr   [fxWbPorts],
  input  logic [regSize-1:0]           candVal    [fxWbPorts],
  input  logic                         candXerEn  [fxWbPorts],
  input  logic [regSize-1:0]           candXerVal [fxWbPorts],
  output logic [2:0]                   drainCount,
  output logic                         portEn     [fxWbPorts],
  output logic [numGPRAddressBits-1:0] portAddr   [fxWbPorts],
  output logic [regSize-1:0]           portVal    [fxWbPorts],
  output logic                         xerEn,
  output logic [regSize-1:0]           xerVal
);

  logic stopScan;
  logic takeEntry;

  always_comb begin
    drainCount = '0;
    xerEn      = 1'b0;
    xerVal     = '0;
    stopScan   = 1'b0;
    takeEntry  = 1'b0;
    for (int i = 0; i < fxWbPorts; i++) begin
      portEn[i]   = 1'b0;
      portAddr[i] = '0;
      portVal[i]  = '0;
    end

    // Selection is a prefix: once an entry is refused, nothing younger may
    // pass it, so every entry before i is already selected when i is checked.
    for (int i = 0; i < fxWbPorts; i++) begin
      takeEntry = !stopScan && (availCount > cntWidth'(i));
      for (int j = 0; j < i; j++) begin
        if (candAddr[j] == candAddr[i]) begin
          takeEntry = 1'b0;
        end
      end
      if (takeEntry) begin
        portEn[i]   = 1'b1;
        portAddr[i] = candAddr[i];
        portVal[i]  = candVal[i];
        drainCount  = drainCount + 3'd1;
        // Later (younger) entries overwrite, leaving the youngest XER value.
        if (candXerEn[i]) begin
          xerEn  = 1'b1;
          xerVal = candXerVal[i];
        end
      end else begin
        stopScan = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fx_writeback_queue.sv
// rtl/fx_writeback_queue.sv - two-in / four-out FX result writeback queue
//
// Purpose: buffers up to two execution results per cycle and retires up to four
// per cycle to the GPR file, never writing the same GPR twice in one group.
//
// Ports:
//   clock_i, reset_i                 rising-edge clock, asynchronous active-high reset
//   res{1,2}Valid_i/Addr_i/Val_i     result inputs, port 1 older than port 2
//   res{1,2}XerEn_i/XerVal_i         result also updates XER, with this data
//   inReady_o                        two free entries available (registered state only)
//   gprWrite{1..4}En_o/Val_o,
//   gprWriteAddr{1..4}_o             registered GPR write ports, oldest on port 1
//   XERWriteEn_o, XERVal_o           registered XER write request
//   occupancy_o                      current entry count
module fx_writeback_queue
  import fx_writeback_queue_pkg::*;
#(
  parameter int unsigned regSize           = fxRegSize,
  parameter int unsigned numGPRAddressBits = fxGprAddrBits,
  parameter int unsigned queueDepth        = fxWbQueueDepth
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         res1Valid_i,
  input  logic [numGPRAddressBits-1:0] res1Addr_i,
  input  logic [regSize-1:0]           res1Val_i,
  input  logic                         res1XerEn_i,
  input  logic [regSize-1:0]           res1XerVal_i,
  input  logic                         res2Valid_i,
  input  logic [numGPRAddressBits-1:0] res2Addr_i,
  input  logic [regSize-1:0]           res2Val_i,
  input  logic                         res2XerEn_i,
  input  logic [regSize-1:0]           res2XerVal_i,
  output logic                         inReady_o,
  output logic                         gprWrite1En_o,
  output logic                         gprWrite2En_o,
  output logic                         gprWrite3En_o,
  output logic                         gprWrite4En_o,
  output logic [numGPRAddressBits-1:0] gprWriteAddr1_o,
  output logic [numGPRAddressBits-1:0] gprWriteAddr2_o,
  output logic [numGPRAddressBits-1:0] gprWriteAddr3_o,
  output logic [numGPRAddressBits-1:0] gprWriteAddr4_o,
  output logic [regSize-1:0]           gprWrite1Val_o,
  output logic [regSize-1:0]           gprWrite2Val_o,
  output logic [regSize-1:0]           gprWrite3Val_o,
  output logic [regSize-1:0]           gprWrite4Val_o,
  output logic                         XERWriteEn_o,
  output logic [regSize-1:0]           XERVal_o,
  output logic [$clog2(queueDepth):0]  occupancy_o
);

  localparam int unsigned ptrWidth   = $clog2(queueDepth);
  localparam int unsigned cntWidth   = ptrWidth + 1;
  localparam int unsigned entryWidth = entryBits(regSize, numGPRAddressBits);
  localparam int unsigned addrLsb    = entryAddrLsb(regSize);
  localparam int unsigned valLsb     = entryValLsb(regSize);
  localparam int unsigned xerEnBit   = entryXerEnBit(regSize);

  logic [entryWidth-1:0] entryMem [queueDepth];
  logic [ptrWidth-1:0]   rdPtr, wrPtr;
  // One bit wider than the pointers so full and empty are distinct values.
  logic [cntWidth-1:0]   count;

  logic                  enq1, enq2;
  logic [1:0]            enqCount;
  logic [entryWidth-1:0] res1Entry, res2Entry;

  logic [numGPRAddressBits-1:0] candAddr   [fxWbPorts];
  logic [regSize-1:0]           candVal    [fxWbPorts];
  logic                         candXerEn  [fxWbPorts];
  logic [regSize-1:0]           candXerVal [fxWbPorts];

  logic [2:0]                   drainCount;
  logic                         selEn   [fxWbPorts];
  logic [numGPRAddressBits-1:0] selAddr [fxWbPorts];
  logic [regSize-1:0]           selVal  [fxWbPorts];
  logic                         selXerEn;
  logic [regSize-1:0]           selXerVal;

  logic                         wrEnQ   [fxWbPorts];
  logic [numGPRAddressBits-1:0] wrAddrQ [fxWbPorts];
  logic [regSize-1:0]           wrValQ  [fxWbPorts];
  logic                         xerEnQ;
  logic [regSize-1:0]           xerValQ;

  // Depends only on the count register, never on this cycle's inputs.
  assign inReady_o = (cntWidth'(queueDepth) - count) >= cntWidth'(2);

  assign enq1     = inReady_o & res1Valid_i;
  assign enq2     = inReady_o & res2Valid_i;
  assign enqCount = {1'b0, enq1} + {1'b0, enq2};

  assign res1Entry = {res1Addr_i, res1Val_i, res1XerEn_i, res1XerVal_i};
  assign res2Entry = {res2Addr_i, res2Val_i, res2XerEn_i, res2XerVal_i};

  // New entries land in free slots, so they never disturb the entries being
  // drained at the same edge. A lone port-2 result takes the first free slot.
  always_ff @(posedge clock_i) begin
    if (enq1) begin
      entryMem[wrPtr] <= res1Entry;
    end
    if (enq2) begin
      entryMem[wrPtr + ptrWidth'(enq1)] <= res2Entry;
    end
  end

  for (genvar g = 0; g < fxWbPorts; g++) begin : gCand
    logic [entryWidth-1:0] candEntry;
    assign candEntry     = entryMem[rdPtr + ptrWidth'(g)];
    assign candAddr[g]   = candEntry[addrLsb +: numGPRAddressBits];
    assign candVal[g]    = candEntry[valLsb +: regSize];
    assign candXerEn[g]  = candEntry[xerEnBit];
    assign candXerVal[g] = candEntry[0 +: regSize];
  end

  fx_wb_select #(
    .regSize          (regSize),
    .numGPRAddressBits(numGPRAddressBits),
    .cntWidth         (cntWidth)
  ) uSelect (
    .availCount(count),
    .candAddr  (candAddr),
    .candVal   (candVal),
    .candXerEn (candXerEn),
    .candXerVal(candXerVal),
    .drainCount(drainCount),
    .portEn    (selEn),
    .portAddr  (selAddr),
    .portVal   (selVal),
    .xerEn     (selXerEn),
    .xerVal    (selXerVal)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= '0;
      xerEnQ  <= 1'b0;
      xerValQ <= '0;
      for (int i = 0; i < fxWbPorts; i++) begin
        wrEnQ[i]   <= 1'b0;
        wrAddrQ[i] <= '0;
        wrValQ[i]  <= '0;
      end
    end else begin
      rdPtr   <= rdPtr + ptrWidth'(drainCount);
      wrPtr   <= wrPtr + ptrWidth'(enqCount);
      count   <= count + cntWidth'(enqCount) - cntWidth'(drainCount);
      xerEnQ  <= selXerEn;
      xerValQ <= selXerVal;
      for (int i = 0; i < fxWbPorts; i++) begin
        wrEnQ[i]   <= selEn[i];
        wrAddrQ[i] <= selAddr[i];
        wrValQ[i]  <= selVal[i];
      end
    end
  end

  assign gprWrite1En_o   = wrEnQ[0];
  assign gprWrite2En_o   = wrEnQ[1];
  assign gprWrite3En_o   = wrEnQ[2];
  assign gprWrite4En_o   = wrEnQ[3];
  assign gprWriteAddr1_o = wrAddrQ[0];
  assign gprWriteAddr2_o = wrAddrQ[1];
  assign gprWriteAddr3_o = wrAddrQ[2];
  assign gprWriteAddr4_o = wrAddrQ[3];
  assign gprWrite1Val_o  = wrValQ[0];
  assign gprWrite2Val_o  = wrValQ[1];
  assign gprWrite3Val_o  = wrValQ[2];
  assign gprWrite4Val_o  = wrValQ[3];
  assign XERWriteEn_o    = xerEnQ;
  assign XERVal_o        = xerValQ;
  assign occupancy_o     = count;

endmodule

// File: tb/tb_fx_writeback_queue.sv
// tb/tb_fx_writeback_queue.sv - self-checking bench for fx_writeback_queue
module tb_fx_writeback_queue;

  localparam int RS    = 64;
  localparam int AB    = 6;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          res1Valid_i, res2Valid_i;
  logic [AB-1:0] res1Addr_i, res2Addr_i;
  logic [RS-1:0] res1Val_i, res2Val_i;
  logic          res1XerEn_i, res2XerEn_i;
  logic [RS-1:0] res1XerVal_i, res2XerVal_i;
  logic          inReady_o;
  logic          gprWrite1En_o, gprWrite2En_o, gprWrite3En_o, gprWrite4En_o;
  logic [AB-1:0] gprWriteAddr1_o, gprWriteAddr2_o, gprWriteAddr3_o, gprWriteAddr4_o;
  logic [RS-1:0] gprWrite1Val_o, gprWrite2Val_o, gprWrite3Val_o, gprWrite4Val_o;
  logic          XERWriteEn_o;
  logic [RS-1:0] XERVal_o;
  logic [3:0]    occupancy_o;

  always #5 clk = ~clk;

  fx_writeback_queue #(.regSize(RS), .numGPRAddressBits(AB), .queueDepth(DEPTH)) dut (
    .clock_i(clk), .reset_i(rst),
    .res1Valid_i(res1Valid_i), .res1Addr_i(res1Addr_i), .res1Val_i(res1Val_i),
    .res1XerEn_i(res1XerEn_i), .res1XerVal_i(res1XerVal_i),
    .res2Valid_i(res2Valid_i), .res2Addr_i(res2Addr_i), .res2Val_i(res2Val_i),
    .res2XerEn_i(res2XerEn_i), .res2XerVal_i(res2XerVal_i),
    .inReady_o(inReady_o),
    .gprWrite1En_o(gprWrite1En_o), .gprWrite2En_o(gprWrite2En_o),
    .gprWrite3En_o(gprWrite3En_o), .gprWrite4En_o(gprWrite4En_o),
    .gprWriteAddr1_o(gprWriteAddr1_o), .gprWriteAddr2_o(gprWriteAddr2_o),
    .gprWriteAddr3_o(gprWriteAddr3_o), .gprWriteAddr4_o(gprWriteAddr4_o),
    .gprWrite1Val_o(gprWrite1Val_o), .gprWrite2Val_o(gprWrite2Val_o),
    .gprWrite3Val_o(gprWrite3Val_o), .gprWrite4Val_o(gprWrite4Val_o),
    .XERWriteEn_o(XERWriteEn_o), .XERVal_o(XERVal_o),
    .occupancy_o(occupancy_o)
  );

  logic          actEn   [4];
  logic [AB-1:0] actAddr [4];
  logic [RS-1:0] actVal  [4];
  assign actEn[0] = gprWrite1En_o;   assign actEn[1] = gprWrite2En_o;
  assign actEn[2] = gprWrite3En_o;   assign actEn[3] = gprWrite4En_o;
  assign actAddr[0] = gprWriteAddr1_o; assign actAddr[1] = gprWriteAddr2_o;
  assign actAddr[2] = gprWriteAddr3_o; assign actAddr[3] = gprWriteAddr4_o;
  assign actVal[0] = gprWrite1Val_o; assign actVal[1] = gprWrite2Val_o;
  assign actVal[2] = gprWrite3Val_o; assign actVal[3] = gprWrite4Val_o;

  typedef struct {
    logic v1; logic [AB-1:0] a1; logic [RS-1:0] d1; logic x1; logic [RS-1:0] xv1;
    logic v2; logic [AB-1:0] a2; logic [RS-1:0] d2; logic x2; logic [RS-1:0] xv2;
  } inVec_t;

  typedef struct {
    inVec_t iv;
    int unsigned occ; logic rdy; logic [3:0] enMask;
    logic [AB-1:0] addr1; logic [RS-1:0] val1;
    logic [AB-1:0] addr2; logic [RS-1:0] val2;
    logic xe; logic [RS-1:0] xv;
  } vec_t;

  typedef struct { logic [AB-1:0] addr; logic [RS-1:0] val; logic xerEn; logic [RS-1:0] xerVal; } ent_t;

  // Reference model: the queue contents in age order, plus the write group
  // expected on the outputs after the most recent edge.
  ent_t          mq[$];
  logic          expEn   [4];
  logic [AB-1:0] expAddr [4];
  logic [RS-1:0] expVal  [4];
  logic          expXe;
  logic [RS-1:0] expXv;

  int passCnt  = 0;
  int totalCnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic inVec_t mkIn(input logic v1, input int a1, input logic [RS-1:0] d1,
                                  input logic x1, input logic [RS-1:0] xv1,
                                  input logic v2, input int a2, input logic [RS-1:0] d2,
                                  input logic x2, input logic [RS-1:0] xv2);
    inVec_t r;
    r.v1 = v1; r.a1 = AB'(a1); r.d1 = d1; r.x1 = x1; r.xv1 = xv1;
    r.v2 = v2; r.a2 = AB'(a2); r.d2 = d2; r.x2 = x2; r.xv2 = xv2;
    return r;
  endfunction

  function automatic vec_t mkVec(input inVec_t iv, input int unsigned occ, input logic rdy,
                                 input logic [3:0] enMask, input int a1, input logic [RS-1:0] v1,
                                 input int a2, input logic [RS-1:0] v2,
                                 input logic xe, input logic [RS-1:0] xv);
    vec_t r;
    r.iv = iv; r.occ = occ; r.rdy = rdy; r.enMask = enMask;
    r.addr1 = AB'(a1); r.val1 = v1; r.addr2 = AB'(a2); r.val2 = v2; r.xe = xe; r.xv = xv;
    return r;
  endfunction

  task automatic setIn(input inVec_t iv);
    res1Valid_i = iv.v1; res1Addr_i = iv.a1; res1Val_i = iv.d1;
    res1XerEn_i = iv.x1; res1XerVal_i = iv.xv1;
    res2Valid_i = iv.v2; res2Addr_i = iv.a2; res2Val_i = iv.d2;
    res2XerEn_i = iv.x2; res2XerVal_i = iv.xv2;
  endtask

  // Apply inputs for one cycle, advance the model across the edge, and leave
  // time just after the edge so outputs can be sampled.
  task automatic drive(input inVec_t iv);
    bit   ready;
    bit   stop;
    bit   conflict;
    int   k;
    ent_t e;
    setIn(iv);
    ready = (DEPTH - mq.size()) >= 2;
    for (int p = 0; p < 4; p++) begin
      expEn[p] = 1'b0; expAddr[p] = '0; expVal[p] = '0;
    end
    expXe = 1'b0; expXv = '0; k = 0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!stop && i < mq.size()) begin
        conflict = 1'b0;
        for (int j = 0; j < i; j++)
          if (mq[j].addr == mq[i].addr) conflict = 1'b1;
        if (conflict) stop = 1'b1;
        else begin
          expEn[i] = 1'b1; expAddr[i] = mq[i].addr; expVal[i] = mq[i].val;
          if (mq[i].xerEn) begin expXe = 1'b1; expXv = mq[i].xerVal; end
          k++;
        end
      end
    end
    repeat (k) void'(mq.pop_front());
    if (ready && iv.v1) begin
      e.addr = iv.a1; e.val = iv.d1; e.xerEn = iv.x1; e.xerVal = iv.xv1; mq.push_back(e);
    end
    if (ready && iv.v2) begin
      e.addr = iv.a2; e.val = iv.d2; e.xerEn = iv.x2; e.xerVal = iv.xv2; mq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkModel(input string tag);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("%s p%0d en", tag, p + 1), 64'(actEn[p]), 64'(expEn[p]));
      chk($sformatf("%s p%0d addr", tag, p + 1), 64'(actAddr[p]), 64'(expAddr[p]));
      chk($sformatf("%s p%0d val", tag, p + 1), actVal[p], expVal[p]);
    end
    chk({tag, " xerEn"}, 64'(XERWriteEn_o), 64'(expXe));
    chk({tag, " xerVal"}, XERVal_o, expXv);
    chk({tag, " occupancy"}, 64'(occupancy_o), 64'(mq.size()));
    chk({tag, " inReady"}, 64'(inReady_o), 64'((DEPTH - mq.size()) >= 2));
  endtask

  task automatic checkQuiet(input string tag);
    chk({tag, " occupancy"}, 64'(occupancy_o), 64'd0);
    chk({tag, " inReady"}, 64'(inReady_o), 64'd1);
    chk({tag, " enables"}, 64'({actEn[3], actEn[2], actEn[1], actEn[0]}), 64'd0);
    chk({tag, " xerEn"}, 64'(XERWriteEn_o), 64'd0);
    chk({tag, " p1 val"}, actVal[0], 64'd0);
    chk({tag, " xerVal"}, XERVal_o, 64'd0);
  endtask

  vec_t   tbl [11];
  inVec_t idle;
  inVec_t rv;

  initial begin
    idle = mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0]  = mkVec(idle, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mkVec(mkIn(1, 0, 10, 0, 0, 1, 1, 11, 0, 0), 2, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mkVec(idle, 0, 1, 4'b0011, 0, 10, 1, 11, 0, 0);
    tbl[3]  = mkVec(mkIn(1, 5, 1, 0, 0, 1, 6, 2, 0, 0), 2, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mkVec(mkIn(1, 5, 3, 0, 0, 1, 7, 4, 0, 0), 2, 1, 4'b0011, 5, 1, 6, 2, 0, 0);
    tbl[5]  = mkVec(idle, 0, 1, 4'b0011, 5, 3, 7, 4, 0, 0);
    tbl[6]  = mkVec(mkIn(1, 8, 'h100, 1, 'hA5, 1, 9, 'h101, 1, 'h3C), 2, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mkVec(idle, 0, 1, 4'b0011, 8, 'h100, 9, 'h101, 1, 'h3C);
    tbl[8]  = mkVec(idle, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mkVec(mkIn(0, 0, 0, 0, 0, 1, 3, 'h33, 0, 0), 1, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    tbl[10] = mkVec(idle, 0, 1, 4'b0001, 3, 'h33, 0, 0, 0, 0);

    // Reset held: quiet outputs, ready asserted.
    setIn(idle);
    repeat (3) @(posedge clk);
    #1;
    checkQuiet("reset");
    rst = 1'b0;

    for (int t = 0; t < 11; t++) begin
      drive(tbl[t].iv);
      chk($sformatf("vec%0d occupancy", t), 64'(occupancy_o), 64'(tbl[t].occ));
      chk($sformatf("vec%0d inReady", t), 64'(inReady_o), 64'(tbl[t].rdy));
      chk($sformatf("vec%0d enables", t), 64'({actEn[3], actEn[2], actEn[1], actEn[0]}), 64'(tbl[t].enMask));
      chk($sformatf("vec%0d p1 addr", t), 64'(actAddr[0]), 64'(tbl[t].addr1));
      chk($sformatf("vec%0d p1 val", t), actVal[0], tbl[t].val1);
      chk($sformatf("vec%0d p2 addr", t), 64'(actAddr[1]), 64'(tbl[t].addr2));
      chk($sformatf("vec%0d p2 val", t), actVal[1], tbl[t].val2);
      chk($sformatf("vec%0d xerEn", t), 64'(XERWriteEn_o), 64'(tbl[t].xe));
      chk($sformatf("vec%0d xerVal", t), XERVal_o, tbl[t].xv);
    end

    // All results target r2: drain is cut to one per cycle, so the queue fills.
    for (int i = 0; i < 6; i++) begin
      drive(mkIn(1, 2, 64'(100 + 2 * i), 0, 0, 1, 2, 64'(101 + 2 * i), 0, 0));
      checkModel("fill");
    end
    chk("fill occupancy at 7", 64'(occupancy_o), 64'd7);
    chk("fill inReady at 7", 64'(inReady_o), 64'd0);
    drive(mkIn(1, 2, 'hDEAD, 0, 0, 1, 4, 'hBEEF, 0, 0));
    checkModel("ignored");
    for (int i = 0; i < 7; i++) begin
      drive(idle);
      checkModel("fill drain");
    end

    // Reset with five entries queued.
    for (int i = 0; i < 4; i++) begin
      drive(mkIn(1, 2, 64'(200 + 2 * i), 0, 0, 1, 2, 64'(201 + 2 * i), 0, 0));
      checkModel("prereset");
    end
    chk("prereset occupancy", 64'(occupancy_o), 64'd5);
    setIn(idle);
    #2;
    rst = 1'b1;
    #1;
    checkQuiet("midreset");
    mq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(idle);
      checkModel("postreset");
    end

    // Randomized traffic: a conflict-heavy busy phase, then a sparse phase.
    for (int c = 0; c < 400; c++) begin
      bit busy;
      busy = (c < 200);
      rv.v1  = busy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      rv.v2  = busy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      rv.a1  = busy ? AB'($urandom_range(0, 3)) : AB'($urandom_range(0, 63));
      rv.a2  = busy ? AB'($urandom_range(0, 3)) : AB'($urandom_range(0, 63));
      rv.d1  = {$urandom, $urandom};
      rv.d2  = {$urandom, $urandom};
      rv.x1  = $urandom_range(0, 1) == 1;
      rv.x2  = $urandom_range(0, 1) == 1;
      rv.xv1 = {$urandom, $urandom};
      rv.xv2 = {$urandom, $urandom};
      drive(rv);
      checkModel($sformatf("rand%0d", c));
    end
    for (int i = 0; i < 4; i++) begin
      drive(idle);
      checkModel("final drain");
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
